// File: rtl/bus_codes_pkg.sv
// Bus source/destination code map shared by the transfer sequencer, the
// bus encoder and the encoder's testbench. Also holds the sequencer FSM
// state type and a one-hot decode helper.
package bus_codes_pkg;

    localparam int CODE_W      = 5;
    localparam int REQ_W       = 2 * CODE_W;
    localparam int NUM_BUS_SRC = 24;
    localparam int NUM_BUS_DST = 24;

    // Source codes: registers R0-R15 then the special bus drivers
    localparam logic [CODE_W-1:0] SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3;
    localparam logic [CODE_W-1:0] SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7;
    localparam logic [CODE_W-1:0] SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11;
    localparam logic [CODE_W-1:0] SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15;
    localparam logic [CODE_W-1:0] SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19;
    localparam logic [CODE_W-1:0] SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_C = 5'd23;

    // Destination codes: code 18 loads Y; Z is only ever loaded by the ALU
    localparam logic [CODE_W-1:0] DST_R0  = 5'd0,  DST_R1  = 5'd1,  DST_R2  = 5'd2,  DST_R3  = 5'd3;
    localparam logic [CODE_W-1:0] DST_R4  = 5'd4,  DST_R5  = 5'd5,  DST_R6  = 5'd6,  DST_R7  = 5'd7;
    localparam logic [CODE_W-1:0] DST_R8  = 5'd8,  DST_R9  = 5'd9,  DST_R10 = 5'd10, DST_R11 = 5'd11;
    localparam logic [CODE_W-1:0] DST_R12 = 5'd12, DST_R13 = 5'd13, DST_R14 = 5'd14, DST_R15 = 5'd15;
    localparam logic [CODE_W-1:0] DST_HI  = 5'd16, DST_LO  = 5'd17, DST_Y   = 5'd18, DST_PC  = 5'd19;
    localparam logic [CODE_W-1:0] DST_MAR = 5'd20, DST_MDR = 5'd21, DST_IR  = 5'd22, DST_OUTPORT = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ERR   = 2'd3
    } xfer_state_e;

    // One-hot decode of a bus code; out-of-range codes decode to all zeros
    function automatic logic [NUM_BUS_SRC-1:0] code_onehot(input logic [CODE_W-1:0] code);
        code_onehot = '0;
        if (code < CODE_W'(NUM_BUS_SRC)) begin
            code_onehot[code] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/xfer_req_fifo.sv
// Small synchronous request queue with flush. Entry storage is not reset;
// only pointers and occupancy are.
module xfer_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the pre-edge count, so a same-edge pop never frees a slot early
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; flush empties the queue in one edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Register-transfer sequencer: pops queued (source, destination) requests,
// drives the one-hot source strobe for SETTLE cycles, then adds the one-hot
// destination load strobe for exactly one cycle.
module bus_xfer_sequencer
    import bus_codes_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int SETTLE     = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [CODE_W-1:0]      req_src,
    input  logic [CODE_W-1:0]      req_dst,
    input  logic                   abort,
    output logic [NUM_BUS_SRC-1:0] src_out,
    output logic [NUM_BUS_DST-1:0] dst_in,
    output logic                   xfer_done,
    output logic                   err_illegal,
    output logic                   busy
);

    logic [REQ_W-1:0]       fifo_rdata;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_pop;
    logic [CODE_W-1:0]      head_src;
    logic [CODE_W-1:0]      head_dst;
    logic                   head_legal;

    xfer_state_e            state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [CODE_W-1:0]      src_q, src_d;
    logic [CODE_W-1:0]      dst_q, dst_d;
    logic [NUM_BUS_SRC-1:0] src_out_q, src_out_d;
    logic [NUM_BUS_DST-1:0] dst_in_q, dst_in_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    xfer_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (abort),
        .push_i  (req_valid && !abort),
        .pop_i   (fifo_pop),
        .wdata_i ({req_src, req_dst}),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign head_src   = fifo_rdata[REQ_W-1:CODE_W];
    assign head_dst   = fifo_rdata[CODE_W-1:0];
    assign head_legal = (head_src < CODE_W'(NUM_BUS_SRC)) && (head_dst < CODE_W'(NUM_BUS_DST));

    assign req_ready   = !fifo_full;
    assign src_out     = src_out_q;
    assign dst_in      = dst_in_q;
    assign xfer_done   = done_q;
    assign err_illegal = err_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

    // Next-state, pop decision and next registered strobes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        dst_d    = dst_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            ST_DRIVE: begin
                if (cnt_q == 2'd0) state_d = ST_LOAD;
                else               cnt_d   = cnt_q - 2'd1;
            end
            default: begin
                // IDLE, LOAD and ERR all start the next request straight away
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    src_d    = head_src;
                    dst_d    = head_dst;
                    if (head_legal) begin
                        state_d = ST_DRIVE;
                        cnt_d   = 2'(SETTLE - 1);
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (abort) begin
            state_d  = ST_IDLE;
            fifo_pop = 1'b0;
        end

        src_out_d = (state_d inside {ST_DRIVE, ST_LOAD}) ? code_onehot(src_d) : '0;
        dst_in_d  = (state_d == ST_LOAD) ? code_onehot(dst_d) : '0;
        done_d    = (state_d == ST_LOAD);
        err_d     = (state_d == ST_ERR);
    end

    // Control state and registered strobes; reset drops every strobe at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            src_out_q <= '0;
            dst_in_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_out_q <= src_out_d;
            dst_in_q  <= dst_in_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Codes of the transfer in flight
    always_ff @(posedge clk) begin
        src_q <= src_d;
        dst_q <= dst_d;
    end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: instance 0 uses SETTLE=1, instance 1 uses
// SETTLE=3, both with a 2-entry queue. Accepted requests are queued as
// expected strobes and matched when the DUT raises xfer_done/err_illegal.
module tb_bus_xfer_sequencer;

    typedef struct packed {
        logic        err;
        logic [23:0] src;
        logic [23:0] dst;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n     [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [4:0]  req_src     [2];
    logic [4:0]  req_dst     [2];
    logic        abort       [2];
    logic [23:0] src_out     [2];
    logic [23:0] dst_in      [2];
    logic        xfer_done   [2];
    logic        err_illegal [2];
    logic        busy        [2];

    exp_t sb_q0[$];
    exp_t sb_q1[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   drive_cnt [2] = '{0, 0};
    int   done_cnt  [2] = '{0, 0};
    int   errp_cnt  [2] = '{0, 0};
    int   done_cyc  [2] = '{-1, -1};
    bit   gap_en    [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bus_xfer_sequencer #(
            .FIFO_DEPTH (2),
            .SETTLE     ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n[g]),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_src     (req_src[g]),
            .req_dst     (req_dst[g]),
            .abort       (abort[g]),
            .src_out     (src_out[g]),
            .dst_in      (dst_in[g]),
            .xfer_done   (xfer_done[g]),
            .err_illegal (err_illegal[g]),
            .busy        (busy[g])
        );
    end

    function automatic logic [23:0] oh(input int c);
        logic [23:0] one;
        one = 24'd1;
        return (c < 24) ? (one << c) : 24'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic mon(input int k);
        exp_t e;
        int   settle;
        bit   have;
        settle = (k == 0) ? 1 : 3;
        if (!reset_n[k]) begin
            drive_cnt[k] = 0;
            return;
        end
        if (xfer_done[k] || err_illegal[k]) begin
            have = (k == 0) ? (sb_q0.size() != 0) : (sb_q1.size() != 0);
            if (!have) begin
                check($sformatf("unexpected_event%0d", k), {30'd0, err_illegal[k], xfer_done[k]}, 32'd0);
            end else begin
                if (k == 0) e = sb_q0.pop_front();
                else        e = sb_q1.pop_front();
                check($sformatf("event_kind%0d", k), {30'd0, err_illegal[k], xfer_done[k]},
                      e.err ? 32'd2 : 32'd1);
                check($sformatf("src_out%0d", k), 32'(src_out[k]), e.err ? 32'd0 : 32'(e.src));
                check($sformatf("dst_in%0d", k), 32'(dst_in[k]), e.err ? 32'd0 : 32'(e.dst));
                if (!e.err) check($sformatf("drive_cycles%0d", k), drive_cnt[k], settle);
            end
            if (xfer_done[k]) begin
                done_cnt[k]++;
                if (gap_en[k] && done_cyc[k] >= 0)
                    check($sformatf("load_gap%0d", k), cyc - done_cyc[k], settle + 1);
                done_cyc[k] = cyc;
            end
            if (err_illegal[k]) errp_cnt[k]++;
            drive_cnt[k] = 0;
        end else if (src_out[k] != 0 && dst_in[k] == 0) begin
            drive_cnt[k]++;
        end else begin
            drive_cnt[k] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Offer one request (called just after a falling edge); returns after the accepting edge
    task automatic send(input int k, input int s, input int d);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        req_valid[k] = 1'b1;
        req_src[k]   = 5'(s);
        req_dst[k]   = 5'(d);
        for (int i = 0; i < 50 && !ok; i++) begin
            if (req_ready[k]) begin
                ok    = 1'b1;
                e.err = (s > 23) || (d > 23);
                e.src = oh(s);
                e.dst = oh(d);
                if (k == 0) sb_q0.push_back(e);
                else        sb_q1.push_back(e);
            end
            @(negedge clk);
        end
        req_valid[k] = 1'b0;
        if (!ok) check($sformatf("send_timeout%0d", k), {31'd0, req_ready[k]}, 32'd1);
    endtask

    task automatic wait_idle(input int k, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            done = !busy[k] && ((k == 0) ? (sb_q0.size() == 0) : (sb_q1.size() == 0));
        end
        if (!done) check($sformatf("drain_timeout%0d", k), {31'd0, busy[k]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, e0;
        for (int k = 0; k < 2; k++) begin
            reset_n[k] = 1'b0; req_valid[k] = 1'b0; req_src[k] = '0; req_dst[k] = '0; abort[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ready%0d", k), {31'd0, req_ready[k]}, 32'd1);
            check($sformatf("rst_src%0d", k), 32'(src_out[k]), 32'd0);
            check($sformatf("rst_dst%0d", k), 32'(dst_in[k]), 32'd0);
            check($sformatf("rst_flags%0d", k), {29'd0, busy[k], err_illegal[k], xfer_done[k]}, 32'd0);
        end
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        @(negedge clk);

        // Single transfer R3 -> R7, SETTLE=1
        send(0, 3, 7);
        check("t1_not_yet", 32'(src_out[0]), 32'd0);
        @(negedge clk);
        check("t1_drive_src", 32'(src_out[0]), 32'h000008);
        check("t1_drive_dst", 32'(dst_in[0]), 32'd0);
        check("t1_busy", {31'd0, busy[0]}, 32'd1);
        @(negedge clk);
        check("t1_load_src", 32'(src_out[0]), 32'h000008);
        check("t1_load_dst", 32'(dst_in[0]), 32'h000080);
        check("t1_load_done", {31'd0, xfer_done[0]}, 32'd1);
        @(negedge clk);
        check("t1_idle_out", 32'(src_out[0] | dst_in[0]), 32'd0);
        check("t1_idle_busy", {31'd0, busy[0]}, 32'd0);

        // Back-to-back transfers fill the 2-entry queue
        d0 = done_cnt[0];
        gap_en[0] = 1'b1;
        done_cyc[0] = -1;
        send(0, 20, 20);
        send(0, 21, 22);
        send(0, 0, 16);
        check("t2_full", {31'd0, req_ready[0]}, 32'd0);
        wait_idle(0, 40);
        gap_en[0] = 1'b0;
        check("t2_loads", done_cnt[0] - d0, 3);

        // Illegal source code then a legal request
        d0 = done_cnt[0];
        e0 = errp_cnt[0];
        send(0, 25, 4);
        send(0, 1, 2);
        wait_idle(0, 40);
        check("t3_errs", errp_cnt[0] - e0, 1);
        check("t3_loads", done_cnt[0] - d0, 1);

        // SETTLE=3 instance: C -> Y
        d0 = done_cnt[1];
        send(1, 23, 18);
        wait_idle(1, 40);
        check("t4_loads", done_cnt[1] - d0, 1);

        // Abort during DRIVE with one request still queued, plus a same-edge push
        d0 = done_cnt[0];
        send(0, 1, 2);
        send(0, 4, 5);
        check("t5_drive", 32'(src_out[0]), 32'h000002);
        abort[0] = 1'b1;
        req_valid[0] = 1'b1;
        req_src[0] = 5'd7;
        req_dst[0] = 5'd7;
        check("t5_ready_abort", {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        abort[0] = 1'b0;
        req_valid[0] = 1'b0;
        sb_q0.delete();
        check("t5_out", 32'(src_out[0] | dst_in[0]), 32'd0);
        check("t5_flags", {30'd0, busy[0], xfer_done[0]}, 32'd0);
        repeat (6) @(negedge clk);
        check("t5_no_done", done_cnt[0] - d0, 0);
        check("t5_busy_after", {31'd0, busy[0]}, 32'd0);

        // Reset pulse in the middle of a LOAD cycle
        send(0, 6, 9);
        @(negedge clk);
        @(negedge clk);
        check("t6_load_dst", 32'(dst_in[0]), 32'h000200);
        #2 reset_n[0] = 1'b0;
        #1;
        check("t6_async_src", 32'(src_out[0]), 32'd0);
        check("t6_async_dst", 32'(dst_in[0]), 32'd0);
        check("t6_async_done", {31'd0, xfer_done[0]}, 32'd0);
        @(posedge clk);
        #2 reset_n[0] = 1'b1;
        @(negedge clk);
        check("t6_ready", {31'd0, req_ready[0]}, 32'd1);
        check("t6_busy", {31'd0, busy[0]}, 32'd0);

        // Random mix of legal and illegal requests on both instances
        for (int i = 0; i < 10; i++) begin
            send(i % 2, $urandom_range(0, 25), $urandom_range(0, 25));
        end
        wait_idle(0, 100);
        wait_idle(1, 100);
        check("sb0_empty", sb_q0.size(), 0);
        check("sb1_empty", sb_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
